alu_mac_accumulator: RTL and testbench

ALU_MAC_ACCUMULATOR -- requirements
Module: alu_mac_accumulator

---
 rtl/alu_mac_accumulator.sv | 105 ++++++++++
 tb/tb_alu_mac_accumulator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mac_accumulator.sv
// Accumulates N ALU results (product or 5-bit sum) into a saturating unsigned Acc.
// Latency: Acc_valid rises the cycle after the Nth term is accepted.
// Backpressure: In_ready only in ACCUM; result held in HOLD until Out_ack.
module alu_mac_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       Count_len,
  input  logic             Mode,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [7:0]       Prod,
  input  logic [3:0]       Sum,
  input  logic             Sum_cout,
  output logic [ACC_W-1:0] Acc,
  output logic             Acc_valid,
  input  logic             Out_ack,
  output logic             Overflow,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       remain;      // terms still to accept, 1..16 during ACCUM
  logic             mode_q;      // run mode latched at Start
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic             start_ok;
  logic             accept;
  logic             last_term;
  logic [ACC_W-1:0] term;
  logic [ACC_W:0]   sum_full;
  logic             sat;

  // Handshake qualifiers: Start counts only in IDLE, terms only in ACCUM.
  assign start_ok  = (state == S_IDLE) && Start;
  assign accept    = (state == S_ACCUM) && In_valid;
  assign last_term = accept && (remain == 5'd1);

  // Term selection and one-bit-wider add so the carry flags saturation.
  always_comb begin
    term     = mode_q ? ACC_W'({Sum_cout, Sum}) : ACC_W'(Prod);
    sum_full = {1'b0, acc_q} + {1'b0, term};
    sat      = sum_full[ACC_W];
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; Start in ACCUM/HOLD and Out_ack outside HOLD fall through unchanged.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok)  state_nxt = S_ACCUM;
      S_ACCUM: if (last_term) state_nxt = S_HOLD;
      S_HOLD:  if (Out_ack)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run setup on Start, then saturating accumulate and countdown on each accepted term.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      remain <= 5'd0;
      mode_q <= 1'b0;
    end else if (start_ok) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      remain <= (Count_len == 4'd0) ? 5'd16 : {1'b0, Count_len};
      mode_q <= Mode;
    end else if (accept) begin
      acc_q  <= sat ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
      ovf_q  <= ovf_q | sat;
      remain <= remain - 5'd1;
    end
  end

  // Status outputs decoded from state alone, so reset clears them immediately.
  always_comb begin
    In_ready  = (state == S_ACCUM);
    Acc_valid = (state == S_HOLD);
    Busy      = (state != S_IDLE);
  end

  assign Acc      = acc_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_mac_accumulator.sv
module tb_alu_mac_accumulator;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [3:0]  Count_len;
  logic        Mode;
  logic        In_valid;
  logic [7:0]  Prod;
  logic [3:0]  Sum;
  logic        Sum_cout;
  logic        Out_ack;

  logic        In_ready, Acc_valid, Overflow, Busy;
  logic [11:0] Acc;
  logic        In_ready10, Acc_valid10, Overflow10, Busy10;
  logic [9:0]  Acc10;

  int tests;
  int fails;

  alu_mac_accumulator #(.ACC_W(12)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Count_len(Count_len), .Mode(Mode),
    .In_valid(In_valid), .In_ready(In_ready), .Prod(Prod), .Sum(Sum), .Sum_cout(Sum_cout),
    .Acc(Acc), .Acc_valid(Acc_valid), .Out_ack(Out_ack), .Overflow(Overflow), .Busy(Busy)
  );

  alu_mac_accumulator #(.ACC_W(10)) dut10 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Count_len(Count_len), .Mode(Mode),
    .In_valid(In_valid), .In_ready(In_ready10), .Prod(Prod), .Sum(Sum), .Sum_cout(Sum_cout),
    .Acc(Acc10), .Acc_valid(Acc_valid10), .Out_ack(Out_ack), .Overflow(Overflow10), .Busy(Busy10)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] len;
    logic       mode;
    logic [7:0] prod;
    logic [3:0] sum;
    logic       cout;
    int         exp12;
    logic       ovf12;
    int         exp10;
    logic       ovf10;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Start a run from IDLE; on return the block is in ACCUM with a cleared accumulator.
  task automatic start_run(input logic [3:0] len, input logic mode);
    @(negedge Clk);
    Start = 1'b1;
    Count_len = len;
    Mode = mode;
    @(negedge Clk);
    Start = 1'b0;
    check("start_in_ready", int'(In_ready), 1);
    check("start_acc_clear", int'(Acc), 0);
    check("start_ovf10_clear", int'(Overflow10), 0);
  endtask

  // Present n back-to-back terms; returns at the negedge after the last accepting edge.
  task automatic feed(input int n, input logic [7:0] p, input logic [3:0] s, input logic c);
    for (int i = 0; i < n; i++) begin
      In_valid = 1'b1;
      Prod = p;
      Sum = s;
      Sum_cout = c;
      @(negedge Clk);
      if (i < n - 1) begin
        check("early_acc_valid", int'(Acc_valid), 0);
        check("mid_in_ready", int'(In_ready), 1);
      end
    end
    In_valid = 1'b0;
    Prod = 8'hA5;
    Sum = 4'h7;
    Sum_cout = 1'b1;
  endtask

  task automatic ack_and_check(input int exp_acc);
    Out_ack = 1'b1;
    @(negedge Clk);
    Out_ack = 1'b0;
    check("ack_valid_drop", int'(Acc_valid), 0);
    check("ack_busy_drop", int'(Busy), 0);
    check("ack_acc_retained", int'(Acc), exp_acc);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Rst_n = 1'b0;
    Start = 1'b0;
    Count_len = 4'd0;
    Mode = 1'b0;
    In_valid = 1'b0;
    Prod = 8'd0;
    Sum = 4'd0;
    Sum_cout = 1'b0;
    Out_ack = 1'b0;

    vecs[0] = '{len: 4'd3, mode: 1'b0, prod: 8'd12,  sum: 4'd15,     cout: 1'b1, exp12: 36,   ovf12: 1'b0, exp10: 36,   ovf10: 1'b0};
    vecs[1] = '{len: 4'd2, mode: 1'b1, prod: 8'd255, sum: 4'b1000,   cout: 1'b1, exp12: 48,   ovf12: 1'b0, exp10: 48,   ovf10: 1'b0};
    vecs[2] = '{len: 4'd0, mode: 1'b0, prod: 8'd255, sum: 4'd0,      cout: 1'b0, exp12: 4080, ovf12: 1'b0, exp10: 1023, ovf10: 1'b1};
    vecs[3] = '{len: 4'd1, mode: 1'b1, prod: 8'd0,   sum: 4'd15,     cout: 1'b1, exp12: 31,   ovf12: 1'b0, exp10: 31,   ovf10: 1'b0};
    vecs[4] = '{len: 4'd6, mode: 1'b0, prod: 8'd200, sum: 4'd3,      cout: 1'b0, exp12: 1200, ovf12: 1'b0, exp10: 1023, ovf10: 1'b1};

    #1;
    check("rst_acc", int'(Acc), 0);
    check("rst_acc_valid", int'(Acc_valid), 0);
    check("rst_in_ready", int'(In_ready), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_overflow", int'(Overflow), 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Table-driven runs with continuous In_valid.
    for (int v = 0; v < 5; v++) begin
      int n;
      n = (vecs[v].len == 4'd0) ? 16 : int'(vecs[v].len);
      start_run(vecs[v].len, vecs[v].mode);
      feed(n, vecs[v].prod, vecs[v].sum, vecs[v].cout);
      check($sformatf("v%0d_acc_valid", v), int'(Acc_valid), 1);
      check($sformatf("v%0d_in_ready_hold", v), int'(In_ready), 0);
      check($sformatf("v%0d_acc", v), int'(Acc), vecs[v].exp12);
      check($sformatf("v%0d_ovf", v), int'(Overflow), int'(vecs[v].ovf12));
      check($sformatf("v%0d_acc10", v), int'(Acc10), vecs[v].exp10);
      check($sformatf("v%0d_ovf10", v), int'(Overflow10), int'(vecs[v].ovf10));
      ack_and_check(vecs[v].exp12);
    end

    // Late acknowledge with Start held high throughout HOLD, including the ack cycle.
    start_run(4'd2, 1'b1);
    feed(2, 8'd0, 4'b1000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      Start = 1'b1;
      @(negedge Clk);
      check("late_ack_valid", int'(Acc_valid), 1);
      check("late_ack_acc", int'(Acc), 48);
    end
    Out_ack = 1'b1;
    @(negedge Clk);
    Out_ack = 1'b0;
    Start = 1'b0;
    check("late_ack_busy", int'(Busy), 0);
    check("late_ack_valid_drop", int'(Acc_valid), 0);
    @(negedge Clk);
    check("late_ack_stays_idle", int'(Busy), 0);
    check("late_ack_acc_kept", int'(Acc), 48);

    // Backpressure: gaps ignore data; Start and Out_ack pulsed mid-run are ignored.
    start_run(4'd3, 1'b0);
    begin
      logic pat [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        In_valid = pat[i];
        Prod = pat[i] ? 8'd5 : 8'd99;
        Start = (i == 2);
        Out_ack = (i == 4);
        if (i == 5) check("bp_ready_before_last", int'(In_ready), 1);
        @(negedge Clk);
      end
      In_valid = 1'b0;
      Start = 1'b0;
      Out_ack = 1'b0;
    end
    check("bp_acc_valid", int'(Acc_valid), 1);
    check("bp_acc", int'(Acc), 15);
    ack_and_check(15);

    // Reset mid-run after two of four terms, then Start on the release edge.
    start_run(4'd4, 1'b0);
    feed(2, 8'd10, 4'd0, 1'b0);
    check("pre_rst_acc", int'(Acc), 20);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_acc", int'(Acc), 0);
    check("mid_rst_in_ready", int'(In_ready), 0);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_valid", int'(Acc_valid), 0);
    check("mid_rst_ovf", int'(Overflow), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Start = 1'b1;
    Count_len = 4'd1;
    Mode = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    check("post_rst_in_ready", int'(In_ready), 1);
    feed(1, 8'd7, 4'd0, 1'b0);
    check("post_rst_valid", int'(Acc_valid), 1);
    check("post_rst_acc", int'(Acc), 7);
    ack_and_check(7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
